// File: rtl/axi4_read_check.sv
// AXI4 read-burst checker: replays the write-test address sequence as
// INCR bursts and verifies every returned beat against its pattern.
module axi4_read_check #(
  parameter logic [31:0]    BASE     = 32'h0,
  parameter int             BURSTLEN = 8,
  parameter int             BURSTS   = 4,
  parameter int             IDW      = 4,
  parameter logic [IDW-1:0] ID       = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [15:0]    errcount,
  output logic [31:0]    m_araddr,
  output logic [7:0]     m_arlen,
  output logic [2:0]     m_arsize,
  output logic [1:0]     m_arburst,
  output logic [IDW-1:0] m_arid,
  output logic [3:0]     m_arcache,
  output logic [2:0]     m_arprot,
  output logic           m_arvalid,
  input  logic           m_arready,
  input  logic [31:0]    m_rdata,
  input  logic [1:0]     m_rresp,
  input  logic [IDW-1:0] m_rid,
  input  logic           m_rlast,
  input  logic           m_rvalid,
  output logic           m_rready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST_BEAT  = 8'(BURSTLEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(BURSTS - 1);
  localparam logic [31:0] BSTEP      = 32'(4 * BURSTLEN);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [15:0] r_burst;
  logic [7:0]  r_beat;
  logic        r_arvalid;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_errcount;

  logic        w_go;
  logic        w_ar_hs;
  logic        w_beat;
  logic        w_last;
  logic        w_bad;
  logic [15:0] w_baddr;
  logic [31:0] w_exp;

  assign w_go    = (r_state == S_IDLE) && start;
  assign w_ar_hs = r_arvalid && m_arready;
  assign w_beat  = (r_state == S_DATA) && m_rvalid;
  assign w_last  = (r_beat == LAST_BEAT);

  // Only the low half of the address feeds the data pattern.
  assign w_baddr = r_addr[15:0] + {6'd0, r_beat, 2'b00};
  assign w_exp   = {~w_baddr, w_baddr};

  assign w_bad = (m_rdata != w_exp)
               || (m_rresp != 2'b00)
               || (m_rid != ID)
               || (m_rlast != w_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_ar_hs) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_beat && w_last) begin
          if (r_burst == LAST_BURST) w_next = S_DONE;
          else w_next = S_ADDR;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_ADDR) || (r_state == S_DATA);
    m_rready  = (r_state == S_DATA);
    m_arvalid = r_arvalid;
    m_araddr  = r_addr;
    m_arlen   = LAST_BEAT;
    m_arsize  = 3'd2;
    m_arburst = 2'd1;
    m_arid    = ID;
    m_arcache = 4'd0;
    m_arprot  = 3'd0;
    done      = r_done;
    error     = r_error;
    errcount  = r_errcount;
  end

  // arvalid is registered, so it trails entry into ADDR by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arvalid <= 1'b0;
    end else begin
      r_arvalid <= (r_state == S_ADDR) && !w_ar_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= BASE;
      r_burst    <= 16'd0;
      r_beat     <= 8'd0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_errcount <= 16'd0;
    end else begin
      if (w_go) begin
        r_addr     <= BASE;
        r_burst    <= 16'd0;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_errcount <= 16'd0;
      end
      if (w_ar_hs) begin
        r_beat <= 8'd0;
      end
      if (w_beat) begin
        if (w_bad) begin
          r_error <= 1'b1;
          if (r_errcount != 16'hFFFF) r_errcount <= r_errcount + 16'd1;
        end
        // The burst ends on the beat count; rlast is only checked.
        if (w_last) begin
          r_addr  <= r_addr + BSTEP;
          r_burst <= r_burst + 16'd1;
          if (r_burst == LAST_BURST) r_done <= 1'b1;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end

endmodule
